// File: rtl/uart_frame_loader_pkg.sv
// Shared constants and state encodings for the UART frame loader.
// SYNC_HEADER_EN adds the SYNC0/SYNC1 header-hunting states.
package uart_frame_loader_pkg;

  localparam int unsigned ADDR_W     = 17;
  localparam int unsigned FRAME_SIZE = 320 * 240;
  localparam logic [7:0]  SYNC0_BYTE = 8'hA5;
  localparam logic [7:0]  SYNC1_BYTE = 8'h5A;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

`ifdef SYNC_HEADER_EN
  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_LOAD  = 3'd1,
    LD_DONE  = 3'd2,
    LD_SYNC0 = 3'd3,
    LD_SYNC1 = 3'd4
  } ld_state_e;
`else
  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } ld_state_e;
`endif

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with input synchroniser, mid-bit sampling and start-glitch rejection.
module uart_rx
  import uart_frame_loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 25000000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       framing_err
);

  localparam int unsigned BIT_CYC  = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_CYC = BIT_CYC / 2;
  localparam int unsigned CNT_W    = $clog2(BIT_CYC + 1);

  logic [1:0]       sync_q, sync_d;
  logic             prev_q, prev_d;
  rx_state_e        st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             rx_s;
  logic             bit_end;

  assign rx_s    = sync_q[1];
  assign bit_end = (cnt_q == CNT_W'(BIT_CYC - 1));

  always_comb begin
    sync_d  = {sync_q[0], rx};
    prev_d  = rx_s;
    st_d    = st_q;
    cnt_d   = CNT_W'(cnt_q + CNT_W'(1));
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (st_q)
      RX_IDLE: begin
        cnt_d = '0;
        // Falling edge only: a line stuck low after a bad stop bit cannot retrigger.
        if (prev_q && !rx_s) st_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CNT_W'(HALF_CYC - 1)) begin
          cnt_d = '0;
          bit_d = 3'd0;
          st_d  = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[7:1]};
          bit_d = 3'(bit_q + 3'd1);
          if (bit_q == 3'd7) st_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          st_d  = RX_IDLE;
          if (rx_s) begin
            data_d  = sh_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: st_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      st_q    <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      sh_q    <= 8'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign framing_err = ferr_q;

endmodule

// File: rtl/uart_frame_loader.sv
// Streams UART bytes into a frame buffer in raster order, SRC_W x SRC_H pixels.
// Define SYNC_HEADER_EN to require a 0xA5 0x5A header before pixel 0.
module uart_frame_loader
  import uart_frame_loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 25000000,
  parameter int unsigned BAUD_RATE = 115200,
  parameter int unsigned SRC_W     = 320,
  parameter int unsigned SRC_H     = 240
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic              load_start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              frame_ready,
  output logic              busy,
  output logic              framing_err
);

  localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(SRC_W - 1);
  localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(SRC_H - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SRC_W);
`ifdef SYNC_HEADER_EN
  localparam ld_state_e ST_ARM = LD_SYNC0;
`else
  localparam ld_state_e ST_ARM = LD_IDLE;
`endif

  logic [7:0] byte_data;
  logic       byte_valid;

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .data        (byte_data),
    .valid       (byte_valid),
    .framing_err (framing_err)
  );

  ld_state_e         st_q, st_d;
  logic [ADDR_W-1:0] x_q, x_d;
  logic [ADDR_W-1:0] y_q, y_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        din_q, din_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  always_comb begin
    st_d    = st_q;
    x_d     = x_q;
    y_d     = y_q;
    row_d   = row_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    ready_d = ready_q;
    if (load_start) begin
      st_d    = ST_ARM;
      x_d     = '0;
      y_d     = '0;
      row_d   = '0;
      ready_d = 1'b0;
    end else if (byte_valid) begin
      case (st_q)
        LD_IDLE, LD_LOAD: begin
          we_d   = 1'b1;
          din_d  = byte_data;
          // row_q tracks y*SRC_W so no multiplier is needed.
          addr_d = ADDR_W'(row_q + x_q);
          st_d   = LD_LOAD;
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              st_d    = LD_DONE;
              ready_d = 1'b1;
            end else begin
              y_d   = ADDR_W'(y_q + ADDR_W'(1));
              row_d = ADDR_W'(row_q + ROW_STEP);
            end
          end else begin
            x_d = ADDR_W'(x_q + ADDR_W'(1));
          end
        end
`ifdef SYNC_HEADER_EN
        LD_SYNC0: st_d = (byte_data == SYNC0_BYTE) ? LD_SYNC1 : LD_SYNC0;
        LD_SYNC1: begin
          if (byte_data == SYNC1_BYTE)      st_d = LD_LOAD;
          else if (byte_data == SYNC0_BYTE) st_d = LD_SYNC1;
          else                              st_d = LD_SYNC0;
        end
`endif
        LD_DONE: st_d = LD_DONE;
        default: st_d = ST_ARM;
      endcase
    end
    busy_d = (st_d == LD_LOAD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= ST_ARM;
      x_q     <= '0;
      y_q     <= '0;
      row_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= 8'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      x_q     <= x_d;
      y_q     <= y_d;
      row_q   <= row_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_din     = din_q;
  assign frame_ready = ready_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Scoreboard bench for uart_frame_loader on a 4x3 frame with a 16-clock bit period.
module tb_uart_frame_loader;

  localparam int unsigned CLK_FREQ  = 16;
  localparam int unsigned BAUD_RATE = 1;
  localparam int unsigned BIT_CYC   = CLK_FREQ / BAUD_RATE;
  localparam int unsigned SRC_W     = 4;
  localparam int unsigned SRC_H     = 3;
  localparam int unsigned NPIX      = SRC_W * SRC_H;

  typedef struct packed {
    logic [16:0] addr;
    logic [7:0]  din;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic        load_start;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [7:0]  mem_din;
  logic        frame_ready;
  logic        busy;
  logic        framing_err;

  int   checks = 0;
  int   errors = 0;
  int   ferr_cnt = 0;
  exp_t exp_q[$];

  uart_frame_loader #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .SRC_W     (SRC_W),
    .SRC_H     (SRC_H)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .load_start  (load_start),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .frame_ready (frame_ready),
    .busy        (busy),
    .framing_err (framing_err)
  );

  always #5 clk = ~clk;

  // Monitor: every write pops one expected entry; framing errors are counted.
  always @(negedge clk) begin
    if (framing_err) ferr_cnt++;
    if (mem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d din=%02h, expected no write", mem_addr, mem_din);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_din !== e.din) begin
          errors++;
          $display("FAIL write: got addr=%0d din=%02h, expected addr=%0d din=%02h",
                   mem_addr, mem_din, e.addr, e.din);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk) rx = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    rx = stop;
    repeat (BIT_CYC) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic expect_write(input int a, input logic [7:0] d);
    exp_t e;
    e.addr = 17'(a);
    e.din  = d;
    exp_q.push_back(e);
  endtask

  task automatic send_header();
`ifdef SYNC_HEADER_EN
    send_byte(8'hA5, 1'b1);
    send_byte(8'h5A, 1'b1);
`endif
  endtask

  task automatic pulse_load_start();
    @(negedge clk) load_start = 1'b1;
    @(negedge clk) load_start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_din"}, 32'(mem_din), 32'd0);
    check({tag, "_frame_ready"}, 32'(frame_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_framing_err"}, 32'(framing_err), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ferr_base;
    reset = 1'b1;
    rx = 1'b1;
    load_start = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // First pixel
    send_header();
    expect_write(0, 8'h3C);
    send_byte(8'h3C, 1'b1);
    check("busy_after_first", 32'(busy), 32'd1);
    check("ready_after_first", 32'(frame_ready), 32'd0);

    // Bad stop bit: pulse only, then the next good byte lands at addr 1
    ferr_base = ferr_cnt;
    send_byte(8'h99, 1'b0);
    check("ferr_pulse_count", 32'(ferr_cnt - ferr_base), 32'd1);
    check("busy_after_ferr", 32'(busy), 32'd1);
    expect_write(1, 8'h42);
    send_byte(8'h42, 1'b1);

    // 2-clock glitch on the line
    ferr_base = ferr_cnt;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT_CYC) @(negedge clk);
    check("glitch_no_ferr", 32'(ferr_cnt - ferr_base), 32'd0);

    // Fill the rest of the frame; last pixel carries 0xFF
    for (int i = 2; i < int'(NPIX); i++) begin
      expect_write(i, 8'(8'hF4 + i));
      send_byte(8'(8'hF4 + i), 1'b1);
    end
    check("ready_after_last", 32'(frame_ready), 32'd1);
    check("busy_after_last", 32'(busy), 32'd0);
    send_byte(8'h55, 1'b1);
    check("ready_held_in_done", 32'(frame_ready), 32'd1);

    // Re-arm, load a partial frame, then reset in the middle of a byte
    pulse_load_start();
    @(negedge clk);
    check("ready_after_rearm", 32'(frame_ready), 32'd0);
    check("busy_after_rearm", 32'(busy), 32'd0);
    send_header();
    for (int i = 0; i < 3; i++) begin
      expect_write(i, 8'(i + 1));
      send_byte(8'(i + 1), 1'b1);
    end
    check("busy_partial", 32'(busy), 32'd1);
    fork
      send_byte(8'hFF, 1'b1);
      begin
        repeat (60) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("midreset");
        reset = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    send_header();
    expect_write(0, 8'h11);
    send_byte(8'h11, 1'b1);
    check("busy_after_reset_load", 32'(busy), 32'd1);

`ifdef SYNC_HEADER_EN
    // Header hunting: stray byte, repeated 0xA5, then the sync word
    pulse_load_start();
    send_byte(8'h12, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h5A, 1'b1);
    expect_write(0, 8'h77);
    send_byte(8'h77, 1'b1);
`endif

    repeat (10) @(negedge clk);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    check("total_ferr", 32'(ferr_cnt), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_loader.md
UART_FRAME_LOADER -- requirements
Module: uart_frame_loader

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 25000000, the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, the serial bit rate.
REQ-003 SHALL have parameter SRC_W, default 320, the frame width in pixels.
REQ-004 SHALL have parameter SRC_H, default 240, the frame height in pixels.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port rx, input, 1 bit: asynchronous UART serial input, idle high.
REQ-008 SHALL have port load_start, input, 1 bit: one-cycle pulse that re-arms the loader for a new frame.
REQ-009 SHALL have port mem_we, output, 1 bit: frame-buffer write enable.
REQ-010 SHALL have port mem_addr, output, 17 bits: frame-buffer address, y*SRC_W+x.
REQ-011 SHALL have port mem_din, output, 8 bits: frame-buffer write data.
REQ-012 SHALL have port frame_ready, output, 1 bit: high while a complete frame is stored.
REQ-013 SHALL have port busy, output, 1 bit: high while a frame is partially loaded.
REQ-014 SHALL have port framing_err, output, 1 bit: one-cycle pulse when a stop bit is sampled low.

Function
REQ-015 SHALL pass rx through a 2-flop synchroniser before any use.
REQ-016 SHALL use BIT_CYC = CLK_FREQ/BAUD_RATE, truncated to an integer (217 at the defaults).
REQ-017 Receiver SHALL detect the start bit on a high-to-low transition of the synchronised rx, re-sample it at BIT_CYC/2, and return to idle without emitting a byte if the sample is high (glitch rejection).
REQ-018 Receiver SHALL sample 8 data bits LSB first, each BIT_CYC apart, starting BIT_CYC after the start-bit mid-sample.
REQ-019 Receiver SHALL sample the stop bit: if high, it pulses byte_valid for 1 cycle; if low, it pulses framing_err for 1 cycle and discards the byte. In both cases it returns to idle, where it requires rx high before the next start bit.
REQ-020 Loader FSM SHALL have states IDLE, LOAD and DONE (plus SYNC0 and SYNC1 when the SYNC_HEADER_EN feature is compiled in; see REQ-031/032).
REQ-021 In IDLE, a valid byte SHALL be written to address 0 and the FSM SHALL move to LOAD.
REQ-022 Each valid byte in IDLE/LOAD SHALL produce mem_we high for exactly 1 cycle, in the cycle after byte_valid, with mem_din set to the byte and mem_addr set to the current pixel index.
REQ-023 The pixel index SHALL increment after each write; x SHALL wrap from SRC_W-1 to 0 with y incrementing.
REQ-024 When the write to index SRC_W*SRC_H-1 occurs, the FSM SHALL enter DONE, and frame_ready SHALL be high from the next cycle.
REQ-025 In DONE, received bytes SHALL be ignored (no mem_we) and frame_ready SHALL stay high.
REQ-026 load_start in any state SHALL clear the pixel index and frame_ready and go to IDLE (or SYNC0 when the feature is compiled in) on the next cycle. A byte_valid in the same cycle as load_start SHALL be discarded.
REQ-027 busy SHALL equal (state==LOAD).
REQ-028 framing_err SHALL NOT advance the pixel index or change the FSM state.

Reset
REQ-029 On reset, SHALL clear the synchroniser to 1, return the receiver to idle, return the FSM to IDLE (or SYNC0 when the feature is compiled in), and zero the pixel index.
REQ-030 On reset, outputs SHALL be: mem_we=0, mem_addr=0, mem_din=0, frame_ready=0, busy=0, framing_err=0. A reset mid-byte or mid-frame SHALL abandon the partial data.

Configuration
REQ-031 With SYNC_HEADER_EN defined, the FSM SHALL require bytes 0xA5 then 0x5A (SYNC0 -> SYNC1 -> LOAD) before pixel 0. Any other byte SHALL return it to SYNC0, except 0xA5 received in SYNC1, which SHALL stay in SYNC1. Header bytes SHALL NOT be written.
REQ-032 Without SYNC_HEADER_EN, the SYNC states SHALL be absent and the first valid byte SHALL be pixel 0.

Structure
REQ-033 A shared package SHALL hold FRAME_SIZE, the address width (17), the SYNC0/SYNC1 byte values and the FSM state encodings.
REQ-034 The serial receiver SHALL be a sub-module, uart_rx (clk, reset, rx, data[7:0], valid, framing_err), mirroring uart_tx.

Verification
REQ-035 Reset, then send 0x3C at 115200 -> one mem_we, addr 0, din 0x3C, busy=1.
REQ-036 Send 76800 bytes of value i%256 -> the last write is addr 76799, din 0xFF; frame_ready=1 and busy=0 next cycle; an extra byte produces no mem_we.
REQ-037 Send a byte with the stop bit low -> framing_err pulses for 1 cycle, no mem_we, index unchanged; the next good byte is written to the same address.
REQ-038 A 2-clock low glitch on rx -> no byte, no framing_err.
REQ-039 After 1000 bytes, assert reset, then send 0x11 -> written to addr 0.
REQ-040 With SYNC_HEADER_EN, send 0x12, 0xA5, 0xA5, 0x5A, 0x77 -> the only write is addr 0, din 0x77.
